rr_request_arbiter8: RTL and testbench
======================================

# rr_request_arbiter8

Round-robin arbiter for eight independent request lines. It sits directly upstream of the team's 8-to-3 encoder. It guarantees the encoder sees at most one active input line at a time, and it asserts the encoder enable only while a grant is live. Fairness comes from a rotating priority pointer. A hold-time limit stops any single requester from starving the others.

## Interface
Parameters:
- HOLD_MAX, 16: maximum consecutive cycles one grant may be held. Legal range is 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high; clears all state immediately
- req  input  8  request lines; req[i] is requester i, level-sensitive
- ack  input  1  consumer release strobe; ends the current grant
- gnt  output 8  one-hot grant (or all zero); gnt[i] drives encoder line Yi
- en   output 1  grant valid; drives encoder enable; equals OR of gnt
- timeout  output 1  one-cycle pulse when a grant is revoked by HOLD_MAX
- ptr  output 3  current round-robin start index, for observability

## Operation
- Every output is registered.
- Reset values: gnt=8'h00, en=0, timeout=0, ptr=3'd0, FSM in IDLE, hold counter 0.
- FSM states are IDLE and GRANT.
- In IDLE, when req != 0:
  - Select the first set bit searching ptr, ptr+1, … wrapping modulo 8.
  - Load gnt with that one-hot value and set en=1.
  - Go to GRANT and clear the hold counter.
- In IDLE, when req == 0: stay in IDLE with gnt=0 and en=0.
- In GRANT, a release occurs when any of the following holds on a clock edge:
  - req of the granted index is 0,
  - ack is 1,
  - the hold counter equals HOLD_MAX-1.
- On release:
  - gnt becomes 0 and en becomes 0.
  - ptr becomes (granted index + 1) mod 8. The 3-bit value wraps naturally, so 7 goes to 0.
  - FSM returns to IDLE.
- When release is caused only by the counter limit (granted req still high, ack=0), timeout=1 for exactly that cycle.
- If multiple release causes coincide, there is exactly one release. timeout is asserted only when neither req-drop nor ack is present.
- In GRANT without release, gnt is held and the counter increments. The counter width is clog2(HOLD_MAX+1) and it never wraps.
- Requests on other lines during GRANT are ignored, not latched. They are re-evaluated in IDLE.
- gnt has at most one bit set at all times, and en == |gnt always holds.

## Timing
- Grant latency: req sampled high at edge k gives gnt/en valid after edge k, i.e. one cycle.
- Maximum hold: a grant stays valid for at most HOLD_MAX cycles. With HOLD_MAX=1, every grant lasts exactly one cycle.
- Release latency: a cause sampled at edge m gives gnt=0 after edge m.
- Next grant is issued after edge m+1 at the earliest. There is always one idle cycle between grants, so the encoder never sees two lines in consecutive cycles.
- Asynchronous rst mid-grant clears gnt and en without waiting for a clock edge. The first grant after rst deasserts uses ptr=0.

## Structure
- Shared package rr_arb_pkg holds:
  - N_REQ = 8 and IDX_W = 3,
  - the FSM state enum (IDLE, GRANT),
  - a one-hot-to-index function used for the ptr update.
- One combinational sub-module, rr_pick8:
  - Inputs: req[7:0] and start[2:0].
  - Outputs: one-hot pick[7:0] and index[2:0].
  - It implements the rotate, priority-find and rotate-back logic.
  - The top level holds only the FSM, counter and registers.

## Test plan
- Reset: assert rst mid-grant (gnt=8'h10). gnt, en, timeout and ptr go to 0 immediately, before any clock edge. After release, req=8'h01 gives gnt=8'h01 one cycle later.
- Rotation: hold req=8'hFF and pulse ack one cycle after each grant. Grants follow 01, 02, 04 … 80, 01, with an en-low cycle between each, and ptr wraps 7→0.
- Priority from pointer: ptr=5 with req=8'b0000_0110. Grant is 8'h02 (wrap search 5,6,7,0,1), and ptr becomes 2 after release.
- Timeout: HOLD_MAX=4, req=8'h08 held, ack=0. gnt=8'h08 lasts exactly 4 cycles, timeout pulses once as gnt clears, and the next grant goes to index 3 again only after an idle cycle.
- Simultaneous causes: at the counter limit, drop req and pulse ack in the same cycle. There is a single release, timeout=0, and ptr advances by one.
- Req drop: req=8'h20 for 3 cycles, then 0. The grant clears one cycle after the drop, en follows gnt, and en is never high while gnt=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, FSM state type and index helper for the round-robin arbiter
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // OR-reduction of set-bit positions; exact for one-hot input, zero for all-zero input
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational first-set-bit search over req starting at index start, wrapping mod 8
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] index
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic             found;

  // rot[j] is requester (start + j) mod 8, so bit 0 is the highest priority
  always_comb begin
    rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = req[start + IDX_W'(j)];
    end
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = IDX_W'(j);
      end
    end
  end

  assign index = start + off;
  assign pick  = found ? (N_REQ'(1) << index) : '0;

endmodule

// File: rtl/rr_request_arbiter8.sv
// rtl/rr_request_arbiter8.sv - eight-line round-robin arbiter with hold limit, feeding an 8-to-3 encoder
module rr_request_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic             en,
  output logic             timeout,
  output logic [IDX_W-1:0] ptr
);

  localparam int              CNT_W   = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             gnt_req;
  logic             at_lim;
  logic             rel;

  rr_pick8 u_pick (
    .req   (req),
    .start (ptr),
    .pick  (pick),
    .index (pick_idx)
  );

  assign gnt_req = |(req & gnt);
  assign at_lim  = (cnt == CNT_LIM);
  assign rel     = !gnt_req || ack || at_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      en      <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= pick;
            en    <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end else begin
            gnt <= '0;
            en  <= 1'b0;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt     <= '0;
            en      <= 1'b0;
            ptr     <= onehot_to_idx(gnt) + 3'd1;
            // only a pure hold-limit revoke is reported
            timeout <= gnt_req && !ack;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_pick_index: assert property (@(posedge clk) disable iff (rst)
    (|pick) |-> (onehot_to_idx(pick) == pick_idx));

endmodule

// File: tb/tb_rr_request_arbiter8.sv
// tb/tb_rr_request_arbiter8.sv - randomized and directed self-checking bench for rr_request_arbiter8
module tb_rr_request_arbiter8;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] gnt;
  logic       en;
  logic       timeout;
  logic [2:0] ptr;

  int total = 0;
  int bad   = 0;

  rr_request_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .gnt     (gnt),
    .en      (en),
    .timeout (timeout),
    .ptr     (ptr)
  );

  always #5 clk = ~clk;

  // reference: who holds the line, for how many visible cycles, and where the search starts
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  function automatic int first_from(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  function automatic logic [7:0] exp_gnt();
    return m_busy ? (8'h01 << m_idx) : 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
      m_ptr  <= 0;
      m_held <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_busy) begin
        if (req != 8'h00) begin
          m_busy <= 1'b1;
          m_idx  <= first_from(req, m_ptr);
          m_held <= 1;
        end
      end else if (!req[m_idx] || ack || m_held == HOLD) begin
        m_busy <= 1'b0;
        m_ptr  <= (m_idx + 1) % 8;
        m_to   <= req[m_idx] && !ack;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  task automatic test_reset();
    #1;
    total++;
    if (gnt !== 8'h00 || en !== 1'b0 || timeout !== 1'b0 || ptr !== 3'd0) begin
      bad++;
      $display("FAIL reset_state gnt=%h en=%b to=%b ptr=%0d want 00/0/0/0", gnt, en, timeout, ptr);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 8'h10;
    @(negedge clk);
    total++;
    if (gnt !== 8'h10 || en !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant gnt=%h en=%b want 10/1", gnt, en);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (gnt !== 8'h00 || en !== 1'b0 || timeout !== 1'b0 || ptr !== 3'd0) begin
      bad++;
      $display("FAIL reset_async gnt=%h en=%b to=%b ptr=%0d want 00/0/0/0", gnt, en, timeout, ptr);
    end
    #1 rst = 1'b0;
    req = 8'h01;
    @(negedge clk);
    total++;
    if (gnt !== 8'h01 || en !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant gnt=%h en=%b want 01/1", gnt, en);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [7:0] seen[$];
    logic       prev_en;
    logic [7:0] last;
    rst = 1'b1;
    #1 rst = 1'b0;
    req     = 8'hFF;
    ack     = 1'b0;
    prev_en = 1'b0;
    last    = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== exp_gnt() || ptr !== 3'(m_ptr) || en !== (gnt != 8'h00)) begin
        bad++;
        $display("FAIL rotation_cycle c=%0d gnt=%h want %h ptr=%0d want %0d en=%b", c, gnt, exp_gnt(), ptr, m_ptr, en);
      end
      if (gnt != 8'h00) begin
        seen.push_back(gnt);
        total++;
        if (prev_en !== 1'b0) begin
          bad++;
          $display("FAIL rotation_gap c=%0d prev_en=%b want 0", c, prev_en);
        end
        last = gnt;
      end else if (last == 8'h80) begin
        total++;
        if (ptr !== 3'd0) begin
          bad++;
          $display("FAIL rotation_wrap ptr=%0d want 0", ptr);
        end
        last = 8'h00;
      end
      prev_en = en;
      ack = (exp_gnt() != 8'h00);
    end
    total++;
    if (seen.size() < 9) begin
      bad++;
      $display("FAIL rotation_count got=%0d want>=9", seen.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (seen[i] !== (8'h01 << (i % 8))) begin
          bad++;
          $display("FAIL rotation_order i=%0d got=%h want=%h", i, seen[i], 8'h01 << (i % 8));
        end
      end
    end
    req = 8'h00;
    ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_priority();
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 8'h10;
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    total++;
    if (ptr !== 3'd5 || gnt !== 8'h00) begin
      bad++;
      $display("FAIL priority_setup ptr=%0d gnt=%h want 5/00", ptr, gnt);
    end
    req = 8'b0000_0110;
    @(negedge clk);
    total++;
    if (gnt !== 8'h02 || en !== 1'b1) begin
      bad++;
      $display("FAIL priority_wrap gnt=%h en=%b want 02/1", gnt, en);
    end
    req = 8'h00;
    @(negedge clk);
    total++;
    if (ptr !== 3'd2 || gnt !== 8'h00) begin
      bad++;
      $display("FAIL priority_ptr ptr=%0d gnt=%h want 2/00", ptr, gnt);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] want_g;
    logic       want_t;
    int         to_count;
    to_count = 0;
    req = 8'h08;
    ack = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      want_g = (c == 5) ? 8'h00 : 8'h08;
      want_t = (c == 5);
      if (timeout) to_count++;
      total++;
      if (gnt !== want_g || timeout !== want_t || en !== (want_g != 8'h00)) begin
        bad++;
        $display("FAIL timeout_seq c=%0d gnt=%h to=%b en=%b want %h/%b", c, gnt, timeout, en, want_g, want_t);
      end
      if (c == 5) begin
        total++;
        if (ptr !== 3'd4) begin
          bad++;
          $display("FAIL timeout_ptr ptr=%0d want 4", ptr);
        end
      end
    end
    total++;
    if (to_count != 1) begin
      bad++;
      $display("FAIL timeout_pulses got=%0d want 1", to_count);
    end
    req = 8'h00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 8'h08) begin
        bad++;
        $display("FAIL simul_hold c=%0d gnt=%h want 08", c, gnt);
      end
    end
    req = 8'h00;
    ack = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== 8'h00 || en !== 1'b0 || timeout !== 1'b0 || ptr !== 3'd4) begin
      bad++;
      $display("FAIL simul_release gnt=%h en=%b to=%b ptr=%0d want 00/0/0/4", gnt, en, timeout, ptr);
    end
    ack = 1'b0;
    @(negedge clk);
    total++;
    if (timeout !== 1'b0 || gnt !== 8'h00) begin
      bad++;
      $display("FAIL simul_after to=%b gnt=%h want 0/00", timeout, gnt);
    end
  endtask

  task automatic test_req_drop();
    req = 8'h20;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 8'h20 || en !== 1'b1) begin
        bad++;
        $display("FAIL drop_hold c=%0d gnt=%h en=%b want 20/1", c, gnt, en);
      end
    end
    req = 8'h00;
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 8'h00 || en !== 1'b0 || timeout !== 1'b0 || ptr !== 3'd6) begin
        bad++;
        $display("FAIL drop_release c=%0d gnt=%h en=%b to=%b ptr=%0d want 00/0/0/6", c, gnt, en, timeout, ptr);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== exp_gnt() || en !== m_busy || timeout !== m_to || ptr !== 3'(m_ptr)) begin
        bad++;
        $display("FAIL random c=%0d gnt=%h/%h en=%b/%b to=%b/%b ptr=%0d/%0d (got/want)",
                 c, gnt, exp_gnt(), en, m_busy, timeout, m_to, ptr, m_ptr);
      end
      total++;
      if ($countones(gnt) > 1 || en !== (gnt != 8'h00)) begin
        bad++;
        $display("FAIL random_onehot c=%0d gnt=%h en=%b want onehot and en==|gnt", c, gnt, en);
      end
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 5) == 0);
    end
    req = 8'h00;
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_priority();
    test_timeout();
    test_simultaneous();
    test_req_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
